// File: rtl/trigger_pkg.sv
// Shared definitions for the multi-stage trigger: config word layout,
// sequencer state encoding and the decoded per-stage configuration.
package trigger_pkg;

    localparam int CFG_DELAY_LSB  = 0;
    localparam int CFG_LEVEL_LSB  = 16;
    localparam int CFG_CH_LSB     = 20;
    localparam int CFG_SERIAL_BIT = 26;
    localparam int CFG_START_BIT  = 27;

    // Widest field sizes the config word can carry; stages use the low bits.
    localparam int CFG_DELAY_MAX_W = 16;
    localparam int CFG_LEVEL_MAX_W = 4;
    localparam int CFG_CH_W        = 5;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FIRED
    } trig_state_e;

    typedef struct packed {
        logic [CFG_DELAY_MAX_W-1:0] delay;
        logic [CFG_LEVEL_MAX_W-1:0] level;
        logic [CFG_CH_W-1:0]        channel;
        logic                       serial;
        logic                       start;
    } stage_cfg_t;

    function automatic stage_cfg_t decode_cfg(input logic [31:0] w);
        stage_cfg_t c;
        c.delay   = w[CFG_DELAY_LSB +: CFG_DELAY_MAX_W];
        c.level   = w[CFG_LEVEL_LSB +: CFG_LEVEL_MAX_W];
        c.channel = w[CFG_CH_LSB +: CFG_CH_W];
        c.serial  = w[CFG_SERIAL_BIT];
        c.start   = w[CFG_START_BIT];
        return c;
    endfunction

endpackage

// File: rtl/trigger_stage.sv
// One trigger stage: parallel or serial pattern match, optional strobe delay,
// and a sticky hit flag. act_o pulses on the strobe at which its action applies.
module trigger_stage
    import trigger_pkg::*;
#(
    parameter int SMPL_W  = 32,
    parameter int DELAY_W = 16,
    parameter int LEVEL_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_in,
    input  logic               arm_i,
    input  logic               stb_i,
    input  logic               armed_i,
    input  logic [LEVEL_W-1:0] level_i,
    input  logic [SMPL_W-1:0]  smpls_i,
    input  logic [31:0]        cmd_i,
    input  logic               set_mask_i,
    input  logic               set_val_i,
    input  logic               set_cfg_i,
    output logic               act_o,
    output logic               start_o,
    output logic               hit_o
);

    logic [SMPL_W-1:0]  mask_q;
    logic [SMPL_W-1:0]  val_q;
    logic [SMPL_W-1:0]  sr_q;
    logic [SMPL_W-1:0]  cmp_word;
    logic [DELAY_W-1:0] cnt_q;
    logic [DELAY_W-1:0] dly;
    stage_cfg_t         cfg_q;
    logic               bit_in;
    logic               match;
    logic               active;
    logic               step;
    logic               counting;
    logic               trig;
    int                 ch;

    // Fields of cmd_i/cfg_q beyond this instance's widths are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{cmd_i, cfg_q};

    always_comb begin
        bit_in = 1'b0;
        ch     = int'(cfg_q.channel) % SMPL_W;
        for (int i = 0; i < SMPL_W; i++) begin
            if (i == ch) bit_in = smpls_i[i];
        end
        cmp_word = cfg_q.serial ? {sr_q[SMPL_W-2:0], bit_in} : smpls_i;
        match    = ((cmp_word ^ val_q) & mask_q) == '0;
        active   = armed_i && (cfg_q.level[LEVEL_W-1:0] == level_i);
        dly      = cfg_q.delay[DELAY_W-1:0];
        step     = stb_i && armed_i && !arm_i;
        counting = cnt_q != '0;
        trig     = step && !counting && active && match;
        act_o    = (step && counting && cnt_q == DELAY_W'(1)) || (trig && dly == '0);
        start_o  = cfg_q.start;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            mask_q <= '0;
            val_q  <= '0;
            cfg_q  <= '0;
            sr_q   <= '0;
            cnt_q  <= '0;
            hit_o  <= 1'b0;
        end else begin
            if (set_mask_i) mask_q <= cmd_i[SMPL_W-1:0];
            if (set_val_i)  val_q  <= cmd_i[SMPL_W-1:0];
            if (set_cfg_i)  cfg_q  <= decode_cfg(cmd_i);
            if (arm_i) begin
                sr_q  <= '0;
                cnt_q <= '0;
                hit_o <= 1'b0;
            end else if (step) begin
                sr_q <= {sr_q[SMPL_W-2:0], bit_in};
                // A running counter ignores new matches until it expires.
                if (counting) begin
                    cnt_q <= cnt_q - DELAY_W'(1);
                end else if (trig) begin
                    hit_o <= 1'b1;
                    cnt_q <= dly;
                end
            end
        end
    end

endmodule

// File: rtl/trigger_seq.sv
// Multi-level trigger sequencer: STAGES pattern stages feed a level counter;
// any stage with start set fires the capture run.
module trigger_seq
    import trigger_pkg::*;
#(
    parameter int SMPL_W  = 32,
    parameter int STAGES  = 4,
    parameter int DELAY_W = 16,
    parameter int LEVEL_W = 2,
    localparam int SEL_W  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic               clk_i,
    input  logic               rst_in,
    input  logic [31:0]        cmd_i,
    input  logic               set_mask_i,
    input  logic               set_val_i,
    input  logic               set_cfg_i,
    input  logic [SEL_W-1:0]   stg_i,
    input  logic               arm_i,
    input  logic               stb_i,
    input  logic [SMPL_W-1:0]  smpls_i,
    output logic               run_o,
    output logic               armed_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic [STAGES-1:0]  hit_o
);

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    trig_state_e        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [STAGES-1:0]  act;
    logic [STAGES-1:0]  start;
    logic               fire;
    logic               advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        trigger_stage #(
            .SMPL_W  (SMPL_W),
            .DELAY_W (DELAY_W),
            .LEVEL_W (LEVEL_W)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_in     (rst_in),
            .arm_i      (arm_i),
            .stb_i      (stb_i),
            .armed_i    (armed_o),
            .level_i    (level_q),
            .smpls_i    (smpls_i),
            .cmd_i      (cmd_i),
            .set_mask_i (set_mask_i && (stg_i == SEL_W'(k))),
            .set_val_i  (set_val_i && (stg_i == SEL_W'(k))),
            .set_cfg_i  (set_cfg_i && (stg_i == SEL_W'(k))),
            .act_o      (act[k]),
            .start_o    (start[k]),
            .hit_o      (hit_o[k])
        );
    end

    // Simultaneous actions merge: any start fires, otherwise one level step.
    assign fire    = |(act & start);
    assign advance = |act;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (arm_i) begin
            state_d = ARMED;
            level_d = '0;
        end else if (state_q == ARMED) begin
            if (fire) begin
                state_d = FIRED;
            end else if (advance && level_q != LEVEL_MAX) begin
                level_d = level_q + LEVEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q <= IDLE;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    assign run_o   = state_q == FIRED;
    assign armed_o = state_q == ARMED;
    assign level_o = level_q;

endmodule
